// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding a DDS phase accumulator: steps a registered
// tuning word between shadowed endpoints in single, sawtooth or triangle mode.
module dds_sweep_ctrl #(
  parameter int M = 27,
  parameter int D = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic [1:0]   mode,
  input  logic [M-1:0] f_start,
  input  logic [M-1:0] f_stop,
  input  logic [M-1:0] f_step,
  input  logic [D-1:0] dwell,
  output logic [M-1:0] P,
  output logic         val_out,
  output logic         ena_ac,
  output logic         rst_ac,
  output logic         busy,
  output logic         done,
  output logic         cfg_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] MODE_SAW = 2'b01;
  localparam logic [1:0] MODE_TRI = 2'b10;

  localparam logic [D-1:0] CNT_ONE = {{(D-1){1'b0}}, 1'b1};

  logic [1:0]   state;
  logic [1:0]   mode_s;
  logic [M-1:0] f_start_s;
  logic [M-1:0] f_stop_s;
  logic [M-1:0] f_step_s;
  logic [D-1:0] dwell_s;
  logic [D-1:0] cnt;
  logic         dir_up;

  logic [M:0]   up_sum;
  logic [M:0]   dn_lim;
  logic [M-1:0] up_word;
  logic [M-1:0] dn_word;
  logic         cfg_ok;

  // One extra bit on both sums so a step near the top of the range saturates
  // at the endpoint instead of wrapping.
  always_comb begin
    up_sum  = {1'b0, P} + {1'b0, f_step_s};
    dn_lim  = {1'b0, f_start_s} + {1'b0, f_step_s};
    up_word = (up_sum >= {1'b0, f_stop_s}) ? f_stop_s : up_sum[M-1:0];
    dn_word = ({1'b0, P} < dn_lim) ? f_start_s : (P - f_step_s);
    cfg_ok  = (f_stop >= f_start);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mode_s    <= '0;
      f_start_s <= '0;
      f_stop_s  <= '0;
      f_step_s  <= '0;
      dwell_s   <= '0;
      cnt       <= '0;
      dir_up    <= 1'b1;
      P         <= '0;
      val_out   <= 1'b0;
      ena_ac    <= 1'b0;
      rst_ac    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;

      if (state != S_IDLE && stop) begin
        state   <= S_IDLE;
        P       <= '0;
        val_out <= 1'b0;
        ena_ac  <= 1'b0;
        rst_ac  <= 1'b1;
        busy    <= 1'b0;
      end else if (state != S_RUN && start) begin
        if (cfg_ok) begin
          mode_s    <= mode;
          f_start_s <= f_start;
          f_stop_s  <= f_stop;
          f_step_s  <= f_step;
          dwell_s   <= dwell;
          cnt       <= dwell;
          dir_up    <= 1'b1;
          P         <= f_start;
          state     <= S_RUN;
          val_out   <= 1'b1;
          ena_ac    <= 1'b1;
          rst_ac    <= 1'b0;
          busy      <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (state == S_RUN) begin
        if (cnt != '0) begin
          cnt <= cnt - CNT_ONE;
        end else begin
          cnt <= dwell_s;
          if (dir_up) begin
            if (P == f_stop_s) begin
              // Top endpoint: restart, turn around, or finish depending on mode.
              if (mode_s == MODE_SAW) begin
                P <= f_start_s;
              end else if (mode_s == MODE_TRI) begin
                dir_up <= 1'b0;
                P      <= dn_word;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end else begin
              P <= up_word;
            end
          end else begin
            if (P == f_start_s) begin
              dir_up <= 1'b1;
              P      <= up_word;
            end else begin
              P <= dn_word;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed vector table, hand-written
// corner sequences, then random traffic against a sweep-list reference model.
module tb_dds_sweep_ctrl;

  localparam int M = 27;
  localparam int D = 16;
  localparam longint TOP = (longint'(1) << M) - 1;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [M-1:0] f_start = '0;
  logic [M-1:0] f_stop = '0;
  logic [M-1:0] f_step = '0;
  logic [D-1:0] dwell = '0;
  logic [M-1:0] P;
  logic         val_out, ena_ac, rst_ac, busy, done, cfg_err;

  dds_sweep_ctrl #(.M(M), .D(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .P(P), .val_out(val_out), .ena_ac(ena_ac), .rst_ac(rst_ac),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the sweep is the ordered list of tuning words visited in
  // one period, each held dwell+1 cycles; the list either ends (DONE) or repeats.
  int      m_st = S_IDLE;
  longint  seq[$];
  bit      m_term;
  int      m_pos, m_hold, m_dwell;
  bit      e_done, e_cfg;

  task automatic model_load();
    longint fs, fe, st, w;
    fs = longint'(f_start);
    fe = longint'(f_stop);
    st = longint'(f_step);
    seq.delete();
    w = fs;
    seq.push_back(w);
    while (w != fe && st != 0) begin
      w = (w + st >= fe) ? fe : w + st;
      seq.push_back(w);
    end
    if (mode == 2'b10 && w == fe && fe != fs) begin
      forever begin
        w = (w < fs + st) ? fs : w - st;
        if (w == fs) break;
        seq.push_back(w);
      end
    end
    m_term  = (mode == 2'b00 || mode == 2'b11) && (st != 0 || fs == fe);
    m_dwell = int'(dwell);
    m_pos   = 0;
    m_hold  = 0;
  endtask

  task automatic model_step();
    e_done = 1'b0;
    e_cfg  = 1'b0;
    if (!rst_n) begin
      m_st = S_IDLE;
    end else if (m_st != S_IDLE && stop) begin
      m_st = S_IDLE;
    end else if (m_st != S_RUN && start) begin
      if (f_stop >= f_start) begin
        model_load();
        m_st = S_RUN;
      end else begin
        e_cfg = 1'b1;
      end
    end else if (m_st == S_RUN) begin
      if (m_hold < m_dwell) begin
        m_hold++;
      end else begin
        m_hold = 0;
        m_pos++;
        if (m_pos == seq.size()) begin
          if (m_term) begin
            m_st   = S_DONE;
            e_done = 1'b1;
            m_pos--;
          end else begin
            m_pos = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return 64'({P, val_out, ena_ac, rst_ac, busy, done, cfg_err});
  endfunction

  function automatic logic [63:0] exp_vec(input longint p, input bit act, input bit dn, input bit cfg);
    logic [M-1:0] pw;
    pw = p[M-1:0];
    return 64'({pw, act, act, !act, act, dn, cfg});
  endfunction

  function automatic logic [63:0] model_vec();
    longint p;
    bit act;
    act = (m_st != S_IDLE);
    p   = act ? seq[m_pos] : 0;
    return exp_vec(p, act, e_done, e_cfg);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_cfg(input bit s, input bit sp, input int md, input longint fs,
                         input longint fe, input longint st, input int dw);
    start   = s;
    stop    = sp;
    mode    = 2'(md);
    f_start = M'(fs);
    f_stop  = M'(fe);
    f_step  = M'(st);
    dwell   = D'(dw);
  endtask

  typedef struct {
    bit     start, stop;
    int     mode;
    longint fs, fe, st;
    int     dw;
    longint p;
    bit     busy, dn, cfg;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit s, input bit sp, input int md, input longint fs,
                              input longint fe, input longint st, input int dw,
                              input longint p, input bit b, input bit dn, input bit cfg);
    vec_t v;
    v.start = s; v.stop = sp; v.mode = md; v.fs = fs; v.fe = fe; v.st = st; v.dw = dw;
    v.p = p; v.busy = b; v.dn = dn; v.cfg = cfg;
    tbl.push_back(v);
  endfunction

  task automatic rand_cfg();
    longint fs, fe, st;
    int rng;
    rng = int'($urandom_range(0, 60));
    if ($urandom_range(0, 3) == 0) fe = TOP - longint'($urandom_range(0, 3));
    else fe = longint'($urandom_range(0, 100000)) + rng;
    fs = fe - rng;
    if ($urandom_range(0, 9) == 0 && fe < TOP - 10) fs = fe + 1 + longint'($urandom_range(0, 5));
    if ($urandom_range(0, 5) == 0) st = 0;
    else if ($urandom_range(0, 9) == 0) st = longint'($urandom_range(0, 200));
    else st = longint'($urandom_range(1, 25));
    f_start = M'(fs);
    f_stop  = M'(fe);
    f_step  = M'(st);
    dwell   = D'($urandom_range(0, 3));
    mode    = 2'($urandom_range(0, 3));
  endtask

  initial begin
    longint ex_a[11] = '{100, 100, 110, 110, 110, 120, 120, 120, 130, 130, 130};
    longint ex_tri[12] = '{0, 10, 20, 10, 0, 10, 20, 10, 0, 10, 20, 10};
    longint ex_saw[10] = '{0, 0, 10, 10, 20, 20, 0, 0, 10, 10};
    int r;

    // Single sweep 100..130 step 10 dwell 2, config inputs scrambled mid-run.
    add(1, 0, 0, 100, 130, 10, 2, 100, 1, 0, 0);
    foreach (ex_a[i]) add(0, 0, 2, 7, 999, 1, 5, ex_a[i], 1, 0, 0);
    add(0, 0, 2, 7, 999, 1, 5, 130, 1, 1, 0);
    add(0, 0, 2, 7, 999, 1, 5, 130, 1, 0, 0);
    add(1, 0, 0, 50, 40, 10, 2, 130, 1, 0, 1);
    add(0, 1, 0, 50, 40, 10, 2, 0, 0, 0, 0);
    add(1, 0, 0, 50, 40, 10, 2, 0, 0, 0, 1);
    add(0, 0, 0, 50, 40, 10, 2, 0, 0, 0, 0);
    // Saturating last step 120 -> 125, then DONE, then stop.
    add(1, 0, 0, 100, 125, 10, 0, 100, 1, 0, 0);
    add(0, 0, 1, 0, 3, 1, 0, 110, 1, 0, 0);
    add(0, 0, 1, 0, 3, 1, 0, 120, 1, 0, 0);
    add(0, 0, 1, 0, 3, 1, 0, 125, 1, 0, 0);
    add(0, 0, 1, 0, 3, 1, 0, 125, 1, 1, 0);
    add(0, 0, 1, 0, 3, 1, 0, 125, 1, 0, 0);
    add(0, 1, 1, 0, 3, 1, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", dut_vec(), exp_vec(0, 0, 0, 0));
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      set_cfg(tbl[i].start, tbl[i].stop, tbl[i].mode, tbl[i].fs, tbl[i].fe, tbl[i].st, tbl[i].dw);
      tick();
      check($sformatf("tbl%0d", i), dut_vec(), exp_vec(tbl[i].p, tbl[i].busy, tbl[i].dn, tbl[i].cfg));
    end

    // Triangle 0/20/10, dwell 0: endpoints visited once per turn, no done.
    set_cfg(1, 0, 2, 0, 20, 10, 0);
    tick();
    check("tri0", 64'({P, done}), 64'({M'(ex_tri[0]), 1'b0}));
    start = 1'b0;
    for (int i = 1; i < 12; i++) begin
      tick();
      check($sformatf("tri%0d", i), 64'({P, done}), 64'({M'(ex_tri[i]), 1'b0}));
    end
    stop = 1'b1;
    tick();
    check("tri_stop", dut_vec(), exp_vec(0, 0, 0, 0));

    // Sawtooth 0/20/10, dwell 1, then start+stop together.
    set_cfg(1, 0, 1, 0, 20, 10, 1);
    tick();
    check("saw0", 64'({P, busy}), 64'({M'(ex_saw[0]), 1'b1}));
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      tick();
      check($sformatf("saw%0d", i), 64'({P, busy}), 64'({M'(ex_saw[i]), 1'b1}));
    end
    start = 1'b1;
    stop  = 1'b1;
    tick();
    check("saw_startstop", dut_vec(), exp_vec(0, 0, 0, 0));

    // Asynchronous reset mid-run, then restart.
    set_cfg(1, 0, 0, 100, 130, 10, 2);
    tick();
    start = 1'b0;
    repeat (4) tick();
    #3;
    rst_n = 1'b0;
    #1;
    m_st = S_IDLE; e_done = 1'b0; e_cfg = 1'b0;
    check("async_rst", dut_vec(), exp_vec(0, 0, 0, 0));
    tick();
    check("rst_hold", dut_vec(), exp_vec(0, 0, 0, 0));
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("post_rst%0d", i), dut_vec(), exp_vec(0, 0, 0, 0));
    end
    set_cfg(1, 0, 0, 100, 130, 10, 2);
    tick();
    check("restart", dut_vec(), exp_vec(100, 1, 0, 0));
    start = 1'b0;
    tick();
    check("restart_hold", dut_vec(), exp_vec(100, 1, 0, 0));

    // Random traffic against the model; config inputs churn every cycle.
    for (int c = 0; c < 4000; c++) begin
      r = int'($urandom_range(0, 99));
      start = (r < 3);
      stop  = (r >= 98);
      rand_cfg();
      tick();
      check($sformatf("rand%0d", c), dut_vec(), model_vec());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
